// File: rtl/mem_access_unit.sv
// MEM-stage access unit: issues load/store transactions on a req/ack bus, stalls
// upstream while an access is outstanding, aligns load data and forwards write-back fields.
module mem_access_unit #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_flag_in,
  input  logic        mem_write_flag_in,
  input  logic        mem_sign_ext_flag_in,
  input  logic [3:0]  mem_sel_in,
  input  logic [31:0] mem_write_data_in,
  input  logic [31:0] result_in,
  input  logic        reg_write_en_in,
  input  logic [4:0]  reg_write_addr_in,
  input  logic [31:0] current_pc_addr_in,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall_request,
  output logic        bus_error,
  output logic [31:0] result_out,
  output logic        reg_write_en_out,
  output logic [4:0]  reg_write_addr_out,
  output logic [31:0] current_pc_addr_out
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;

  localparam logic [7:0] TIMEOUT = 8'(ACK_TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mem_op;
  logic        req_raw, err_raw, stall_raw;
  logic [7:0]  cnt_inc;
  logic [31:0] load_data;

  assign mem_op  = mem_read_flag_in | mem_write_flag_in;
  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_raw   = 1'b0;
    err_raw   = 1'b0;
    stall_raw = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          req_raw   = 1'b1;
          stall_raw = 1'b1;
          cnt_d     = '0;
          state_d   = bus_ack ? DONE : BUSY;
        end
      end
      BUSY: begin
        req_raw   = 1'b1;
        stall_raw = 1'b1;
        cnt_d     = cnt_inc;
        // cnt_q counts earlier BUSY wait cycles; cnt_inc includes the current one.
        if (bus_ack)
          state_d = DONE;
        else if (TIMEOUT != 8'd0 && cnt_inc == TIMEOUT)
          state_d = ERR;
      end
      DONE:    state_d = IDLE;
      ERR: begin
        err_raw = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Gating with rst makes the bus handshake and stall drop the moment reset asserts.
  assign bus_req       = rst & req_raw;
  assign stall_request = rst & stall_raw;
  assign bus_error     = rst & err_raw;

  assign rdata_d = (bus_req && bus_ack) ? bus_rdata : rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus_we   = mem_write_flag_in & ~mem_read_flag_in;
  assign bus_addr = {result_in[31:2], 2'b00};
  assign bus_sel  = mem_sel_in;

  always_comb begin
    case (mem_sel_in)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: bus_wdata = {4{mem_write_data_in[7:0]}};
      4'b0011, 4'b1100:                   bus_wdata = {2{mem_write_data_in[15:0]}};
      default:                            bus_wdata = mem_write_data_in;
    endcase
  end

  always_comb begin
    load_data = '0;
    case (mem_sel_in)
      4'b0001: load_data = {{24{mem_sign_ext_flag_in & rdata_q[7]}},  rdata_q[7:0]};
      4'b0010: load_data = {{24{mem_sign_ext_flag_in & rdata_q[15]}}, rdata_q[15:8]};
      4'b0100: load_data = {{24{mem_sign_ext_flag_in & rdata_q[23]}}, rdata_q[23:16]};
      4'b1000: load_data = {{24{mem_sign_ext_flag_in & rdata_q[31]}}, rdata_q[31:24]};
      4'b0011: load_data = {{16{mem_sign_ext_flag_in & rdata_q[15]}}, rdata_q[15:0]};
      4'b1100: load_data = {{16{mem_sign_ext_flag_in & rdata_q[31]}}, rdata_q[31:16]};
      4'b1111: load_data = rdata_q;
      default: load_data = '0;
    endcase
  end

  always_comb begin
    result_out       = result_in;
    reg_write_en_out = reg_write_en_in;
    if (state_q == DONE && mem_read_flag_in) begin
      result_out = load_data;
    end else if (state_q == ERR) begin
      result_out       = '0;
      reg_write_en_out = 1'b0;
    end
  end

  assign reg_write_addr_out  = reg_write_addr_in;
  assign current_pc_addr_out = current_pc_addr_in;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: single-cycle-ack vector table plus
// hand-written multi-cycle sequences (wait states, timeout, async reset, back-to-back).
module tb_mem_access_unit;

  logic        clk, rst;
  logic        rd, wr, sx, we_en;
  logic [3:0]  sel;
  logic [31:0] wd, res, pc;
  logic [4:0]  wa;
  logic        ack;
  logic [31:0] rdata;
  logic        bus_req, bus_we, stall, bus_error, we_out;
  logic [31:0] bus_addr, bus_wdata, result_out, pc_out;
  logic [3:0]  bus_sel;
  logic [4:0]  wa_out;

  int unsigned npass = 0;
  int unsigned ntotal = 0;

  mem_access_unit #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .mem_read_flag_in(rd), .mem_write_flag_in(wr), .mem_sign_ext_flag_in(sx),
    .mem_sel_in(sel), .mem_write_data_in(wd), .result_in(res),
    .reg_write_en_in(we_en), .reg_write_addr_in(wa), .current_pc_addr_in(pc),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
    .bus_wdata(bus_wdata), .bus_ack(ack), .bus_rdata(rdata),
    .stall_request(stall), .bus_error(bus_error), .result_out(result_out),
    .reg_write_en_out(we_out), .reg_write_addr_out(wa_out), .current_pc_addr_out(pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rd, wr, sx;
    logic [3:0]  sel;
    logic [31:0] wd, res, rdata, exp_addr;
    logic        exp_we;
    logic [31:0] exp_wdata, exp_result;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs(input logic [31:0] r);
    rd = 0; wr = 0; sx = 0; sel = 4'b0000; wd = '0; res = r; ack = 0; rdata = '0;
  endtask

  // Applies one vector with an immediate ack; starts and ends at posedge+1 in IDLE.
  task automatic run_vec(input vec_t v, input int unsigned idx);
    logic mop;
    mop = v.rd | v.wr;
    rd = v.rd; wr = v.wr; sx = v.sx; sel = v.sel; wd = v.wd; res = v.res;
    rdata = v.rdata; ack = mop;
    wa = 5'(idx + 3); pc = 32'h4000_0000 + 32'(idx * 4);
    @(negedge clk);
    chk($sformatf("v%0d req", idx), 32'(bus_req), 32'(mop));
    chk($sformatf("v%0d stall", idx), 32'(stall), 32'(mop));
    chk($sformatf("v%0d wa_pass", idx), 32'(wa_out), 32'(idx + 3));
    chk($sformatf("v%0d pc_pass", idx), pc_out, 32'h4000_0000 + 32'(idx * 4));
    if (mop) begin
      chk($sformatf("v%0d addr", idx), bus_addr, v.exp_addr);
      chk($sformatf("v%0d sel", idx), 32'(bus_sel), 32'(v.sel));
      chk($sformatf("v%0d we", idx), 32'(bus_we), 32'(v.exp_we));
      if (v.exp_we) chk($sformatf("v%0d wdata", idx), bus_wdata, v.exp_wdata);
      next_cycle();
      ack = 0; rdata = 32'h0BAD_0BAD;
      @(negedge clk);
      chk($sformatf("v%0d done_req", idx), 32'(bus_req), 32'd0);
      chk($sformatf("v%0d done_stall", idx), 32'(stall), 32'd0);
      chk($sformatf("v%0d done_wen", idx), 32'(we_out), 32'd1);
    end
    chk($sformatf("v%0d result", idx), result_out, v.exp_result);
    next_cycle();
    idle_inputs(32'h0);
  endtask

  // Byte load at 0x100, lane 2, acked in the fourth request cycle.
  task automatic byte_load(input logic s, input logic [31:0] exp);
    int unsigned n;
    logic done;
    n = 0; done = 0;
    rd = 1; sel = 4'b0100; res = 32'h100; sx = s; rdata = 32'h0080_0000;
    for (int c = 0; c < 20 && !done; c++) begin
      ack = (c == 3);
      @(negedge clk);
      if (c == 0) chk("bl_addr", bus_addr, 32'h100);
      if (stall) n++;
      else begin
        done = 1;
        chk("bl_result", result_out, exp);
      end
      next_cycle();
    end
    chk("bl_done_seen", 32'(done), 32'd1);
    chk("bl_stall_cycles", n, 4);
    idle_inputs(32'h0);
  endtask

  initial begin
    int unsigned n;
    logic seen;
    vec_t dv;

    vecs[0]  = '{0,0,0,4'b0000,32'h0,32'h1234_5678,32'h0,32'h1234_5678,0,32'h0,32'h1234_5678};
    vecs[1]  = '{1,0,1,4'b0001,32'h0,32'h0000_0104,32'h0000_00F0,32'h104,0,32'h0,32'hFFFF_FFF0};
    vecs[2]  = '{1,0,0,4'b0010,32'h0,32'h0000_0105,32'h0000_AB00,32'h104,0,32'h0,32'h0000_00AB};
    vecs[3]  = '{1,0,1,4'b0011,32'h0,32'h0000_0202,32'h1234_8001,32'h200,0,32'h0,32'hFFFF_8001};
    vecs[4]  = '{1,0,0,4'b1100,32'h0,32'h0000_0302,32'h8001_0000,32'h300,0,32'h0,32'h0000_8001};
    vecs[5]  = '{1,0,1,4'b1000,32'h0,32'h0000_0407,32'h7F00_0000,32'h404,0,32'h0,32'h0000_007F};
    vecs[6]  = '{1,0,1,4'b1111,32'h0,32'h0000_0500,32'hCAFE_F00D,32'h500,0,32'h0,32'hCAFE_F00D};
    vecs[7]  = '{1,0,1,4'b0101,32'h0,32'h0000_0600,32'hFFFF_FFFF,32'h600,0,32'h0,32'h0};
    vecs[8]  = '{0,1,0,4'b0100,32'h0000_00A5,32'h0000_0203,32'h0,32'h200,1,32'hA5A5_A5A5,32'h0000_0203};
    vecs[9]  = '{0,1,0,4'b1100,32'h0000_ABCD,32'h0000_0010,32'h0,32'h10,1,32'hABCD_ABCD,32'h10};
    vecs[10] = '{0,1,0,4'b1111,32'h1122_3344,32'h0000_0020,32'h0,32'h20,1,32'h1122_3344,32'h20};
    vecs[11] = '{1,1,0,4'b1111,32'h5555_5555,32'h0000_0030,32'h8765_4321,32'h30,0,32'h0,32'h8765_4321};

    rst = 0; we_en = 1; wa = 5'd1; pc = 32'h0;
    idle_inputs(32'h1234_5678);
    #12;
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_err", 32'(bus_error), 32'd0);
    chk("rst_result", result_out, 32'h1234_5678);
    next_cycle();
    rst = 1;
    next_cycle();

    foreach (vecs[i]) run_vec(vecs[i], i);

    byte_load(1'b1, 32'hFFFF_FF80);
    byte_load(1'b0, 32'h0000_0080);

    // Timeout: load never acked.
    rd = 1; sel = 4'b1111; res = 32'h700; ack = 0; n = 0; seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (bus_req) n++;
      else begin
        seen = 1;
        chk("to_err", 32'(bus_error), 32'd1);
        chk("to_wen", 32'(we_out), 32'd0);
        chk("to_result", result_out, 32'h0);
        chk("to_stall", 32'(stall), 32'd0);
      end
      next_cycle();
    end
    chk("to_seen", 32'(seen), 32'd1);
    chk("to_req_cycles", n, 5);
    idle_inputs(32'h77);
    ack = 1; rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("late_err", 32'(bus_error), 32'd0);
    chk("late_req", 32'(bus_req), 32'd0);
    chk("late_result", result_out, 32'h77);
    next_cycle();
    ack = 0;
    @(negedge clk);
    chk("late_err2", 32'(bus_error), 32'd0);
    chk("late_stall2", 32'(stall), 32'd0);
    next_cycle();

    // Async reset in BUSY.
    rd = 1; sel = 4'b1111; res = 32'h800; ack = 0;
    next_cycle();
    @(negedge clk);
    chk("pre_rst_busy", 32'(stall), 32'd1);
    #2 rst = 0;
    #1;
    chk("arst_req", 32'(bus_req), 32'd0);
    chk("arst_stall", 32'(stall), 32'd0);
    idle_inputs(32'h0);
    next_cycle();
    next_cycle();
    rst = 1;
    next_cycle();
    dv = '{1,0,0,4'b1111,32'h0,32'h0000_0900,32'hDEAD_BEEF,32'h900,0,32'h0,32'hDEAD_BEEF};
    run_vec(dv, 12);

    // Back-to-back load then store.
    n = 0;
    rd = 1; sel = 4'b1111; res = 32'hA00; ack = 1; rdata = 32'h1357_9BDF;
    @(negedge clk); if (bus_req) n++;
    next_cycle();
    ack = 0;
    @(negedge clk); if (bus_req) n++;
    chk("b2b_done1", result_out, 32'h1357_9BDF);
    chk("b2b_done1_stall", 32'(stall), 32'd0);
    next_cycle();
    rd = 0; wr = 1; sel = 4'b0001; wd = 32'h0000_003C; res = 32'hB04; ack = 1;
    @(negedge clk); if (bus_req) n++;
    chk("b2b_store_wdata", bus_wdata, 32'h3C3C_3C3C);
    chk("b2b_store_we", 32'(bus_we), 32'd1);
    next_cycle();
    ack = 0;
    @(negedge clk); if (bus_req) n++;
    chk("b2b_done2", result_out, 32'hB04);
    chk("b2b_req_count", n, 2);
    next_cycle();
    idle_inputs(32'h0);
    next_cycle();

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
